// File: rtl/i2c_byte_ctl.sv
// i2c_byte_ctl: byte-level I2C master sequencer.
// Turns one byte request (optional START, WRITE or READ with an acknowledge
// phase, optional STOP) into single-bit commands for the I2C bit controller.
// It returns the received byte, the slave ACK and a one-cycle completion pulse.
module i2c_byte_ctl (
  input  logic       sysclk,
  input  logic       nReset,
  input  logic       enable,
  input  logic       go,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       busy,
  output logic       arblost,
  output logic [2:0] bit_cmd,
  output logic       bit_txd,
  input  logic       bit_ack,
  input  logic       bit_rxd,
  input  logic       bit_arblost
);

  localparam logic [2:0] CMD_IDLE   = 3'd0;
  localparam logic [2:0] CMD_START  = 3'd1;
  localparam logic [2:0] CMD_STOP   = 3'd2;
  localparam logic [2:0] CMD_WRITE  = 3'd3;
  localparam logic [2:0] CMD_READ   = 3'd4;
  localparam logic [2:0] CMD_WR_ACK = 3'd5;
  localparam logic [2:0] CMD_RD_ACK = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_ACK, ST_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       stop_q, stop_d;
  logic       write_q, write_d;
  logic       read_q, read_d;
  logic       ack_in_q, ack_in_d;
  logic [2:0] bit_cmd_q, bit_cmd_d;
  logic       bit_txd_q, bit_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       busy_q, busy_d;
  logic       arblost_q, arblost_d;
  logic       req_any;

  // A go strobe with no flag set carries no work and is dropped.
  assign req_any = start | stop | read | write;

  // State and output registers; asynchronous reset puts every output at its idle value.
  always_ff @(posedge sysclk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      sr_q      <= 8'h00;
      stop_q    <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      ack_in_q  <= 1'b0;
      bit_cmd_q <= CMD_IDLE;
      bit_txd_q <= 1'b1;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b1;
      busy_q    <= 1'b0;
      arblost_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      stop_q    <= stop_d;
      write_q   <= write_d;
      read_q    <= read_d;
      ack_in_q  <= ack_in_d;
      bit_cmd_q <= bit_cmd_d;
      bit_txd_q <= bit_txd_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      busy_q    <= busy_d;
      arblost_q <= arblost_d;
    end
  end

  // Next-state logic: the next bit command is chosen in the same edge that
  // consumes bit_ack, so the bit controller never samples a stale command.
  // busy stays high through the cmd_ack cycle so a back-to-back go keeps it up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    stop_d    = stop_q;
    write_d   = write_q;
    read_d    = read_q;
    ack_in_d  = ack_in_q;
    bit_cmd_d = bit_cmd_q;
    bit_txd_d = bit_txd_q;
    cmd_ack_d = 1'b0;
    ack_out_d = ack_out_q;
    busy_d    = busy_q;
    arblost_d = arblost_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = 3'd0;
      sr_d      = 8'h00;
      stop_d    = 1'b0;
      write_d   = 1'b0;
      read_d    = 1'b0;
      ack_in_d  = 1'b0;
      bit_cmd_d = CMD_IDLE;
      bit_txd_d = 1'b1;
      ack_out_d = 1'b1;
      busy_d    = 1'b0;
      arblost_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      busy_d = 1'b0;
      if (go && req_any) begin
        stop_d    = stop;
        write_d   = write;
        read_d    = read;
        ack_in_d  = ack_in;
        sr_d      = din;
        cnt_d     = 3'd0;
        arblost_d = 1'b0;
        busy_d    = 1'b1;
        if (start) begin
          state_d   = ST_START;
          bit_cmd_d = CMD_START;
          bit_txd_d = 1'b1;
        end else if (write) begin
          state_d   = ST_WRITE;
          bit_cmd_d = CMD_WRITE;
          bit_txd_d = din[7];
        end else if (read) begin
          state_d   = ST_READ;
          bit_cmd_d = CMD_READ;
          bit_txd_d = 1'b1;
        end else begin
          state_d   = ST_STOP;
          bit_cmd_d = CMD_STOP;
          bit_txd_d = 1'b1;
        end
      end
    end else if (bit_arblost) begin
      // Lost the bus: abandon the transaction without a STOP.
      state_d   = ST_IDLE;
      cnt_d     = 3'd0;
      bit_cmd_d = CMD_IDLE;
      bit_txd_d = 1'b1;
      arblost_d = 1'b1;
      cmd_ack_d = 1'b1;
    end else if (bit_ack) begin
      case (state_q)
        ST_START: begin
          if (write_q) begin
            state_d   = ST_WRITE;
            bit_cmd_d = CMD_WRITE;
            bit_txd_d = sr_q[7];
          end else if (read_q) begin
            state_d   = ST_READ;
            bit_cmd_d = CMD_READ;
            bit_txd_d = 1'b1;
          end else if (stop_q) begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
            bit_txd_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_IDLE;
            bit_txd_d = 1'b1;
            cmd_ack_d = 1'b1;
          end
        end
        ST_WRITE: begin
          sr_d  = {sr_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d   = ST_ACK;
            bit_cmd_d = CMD_RD_ACK;
            bit_txd_d = 1'b1;
          end else begin
            bit_txd_d = sr_q[6];
          end
        end
        ST_READ: begin
          sr_d  = {sr_q[6:0], bit_rxd};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d   = ST_ACK;
            bit_cmd_d = CMD_WR_ACK;
            bit_txd_d = ack_in_q;
          end
        end
        ST_ACK: begin
          if (write_q) begin
            ack_out_d = bit_rxd;
          end
          if (stop_q) begin
            state_d   = ST_STOP;
            bit_cmd_d = CMD_STOP;
            bit_txd_d = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_IDLE;
            bit_txd_d = 1'b1;
            cmd_ack_d = 1'b1;
          end
        end
        ST_STOP: begin
          state_d   = ST_IDLE;
          bit_cmd_d = CMD_IDLE;
          bit_txd_d = 1'b1;
          cmd_ack_d = 1'b1;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cmd_d = CMD_IDLE;
          bit_txd_d = 1'b1;
        end
      endcase
    end
  end

  assign cmd_ack = cmd_ack_q;
  assign ack_out = ack_out_q;
  assign dout    = sr_q;
  assign busy    = busy_q;
  assign arblost = arblost_q;
  assign bit_cmd = bit_cmd_q;
  assign bit_txd = bit_txd_q;

endmodule

// File: tb/tb_i2c_byte_ctl.sv
// Testbench for i2c_byte_ctl: a behavioural bit controller answers every bit
// command and checks it against a queue of expected commands; a completion
// monitor checks each cmd_ack against a queue of expected results.
module tb_i2c_byte_ctl;

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_STOP  = 3'd2;
  localparam logic [2:0] C_WRITE = 3'd3;
  localparam logic [2:0] C_READ  = 3'd4;
  localparam logic [2:0] C_WRACK = 3'd5;
  localparam logic [2:0] C_RDACK = 3'd6;

  logic       sysclk = 1'b0;
  logic       nReset = 1'b0;
  logic       enable = 1'b1;
  logic       go = 1'b0, start = 1'b0, stop = 1'b0, write = 1'b0, read = 1'b0, ack_in = 1'b0;
  logic [7:0] din = 8'h00;
  logic       cmd_ack, ack_out, busy, arblost, bit_txd;
  logic [7:0] dout;
  logic [2:0] bit_cmd;
  logic       bit_ack = 1'b0, bit_rxd = 1'b1, bit_arblost = 1'b0;

  typedef struct {
    logic [2:0] cmd;
    logic       txd;
    bit         chk_txd;
  } cmd_exp_t;

  typedef struct {
    logic       ack_out;
    bit         chk_ack;
    logic [7:0] dout;
    bit         chk_dout;
    logic       arblost;
  } done_exp_t;

  cmd_exp_t  exp_cmd_q[$];
  done_exp_t exp_done_q[$];
  logic      rx_q[$];
  int        n_cmp = 0;
  int        n_err = 0;
  int        txn_idx = 0;
  int        arb_idx = -1;

  i2c_byte_ctl dut (
    .sysclk(sysclk), .nReset(nReset), .enable(enable), .go(go),
    .start(start), .stop(stop), .write(write), .read(read), .ack_in(ack_in),
    .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout), .busy(busy),
    .arblost(arblost), .bit_cmd(bit_cmd), .bit_txd(bit_txd), .bit_ack(bit_ack),
    .bit_rxd(bit_rxd), .bit_arblost(bit_arblost)
  );

  initial forever #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic t, input bit ck);
    cmd_exp_t e;
    e.cmd = c; e.txd = t; e.chk_txd = ck;
    exp_cmd_q.push_back(e);
  endtask

  task automatic push_writes(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) push_cmd(C_WRITE, b[i], 1'b1);
  endtask

  task automatic push_reads(input int n);
    for (int i = 0; i < n; i++) push_cmd(C_READ, 1'b1, 1'b0);
  endtask

  task automatic push_rx(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) rx_q.push_back(b[i]);
  endtask

  task automatic push_done(input logic a, input bit ca, input logic [7:0] d, input bit cd, input logic arb);
    done_exp_t e;
    e.ack_out = a; e.chk_ack = ca; e.dout = d; e.chk_dout = cd; e.arblost = arb;
    exp_done_q.push_back(e);
  endtask

  // Drive a go strobe starting now (caller is at a falling edge).
  task automatic drive_go(input logic s, input logic p, input logic w, input logic r,
                          input logic a, input logic [7:0] d);
    start = s; stop = p; write = w; read = r; ack_in = a; din = d; go = 1'b1;
    txn_idx = 0;
    @(negedge sysclk);
    go = 1'b0; start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0; ack_in = 1'b0; din = 8'h00;
  endtask

  task automatic issue(input logic s, input logic p, input logic w, input logic r,
                       input logic a, input logic [7:0] d);
    @(negedge sysclk);
    drive_go(s, p, w, r, a, d);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_done_q.size() != 0 || exp_cmd_q.size() != 0) && k < 400) begin
      @(negedge sysclk); #1;
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_err++;
      $display("FAIL %s_timeout: %0d cmds and %0d completions pending, required 0",
               name, exp_cmd_q.size(), exp_done_q.size());
    end
    @(negedge sysclk); #1;
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_bit_cmd_idle"}, bit_cmd, C_IDLE);
  endtask

  task automatic wait_idx(input string name, input int n);
    int k;
    k = 0;
    while (txn_idx < n && k < 200) begin
      @(negedge sysclk); #1;
      k++;
    end
    n_cmp++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL %s_wait: saw %0d bit commands, required %0d", name, txn_idx, n);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_bit_cmd"}, bit_cmd, C_IDLE);
    chk({name, "_bit_txd"}, bit_txd, 1);
    chk({name, "_cmd_ack"}, cmd_ack, 0);
    chk({name, "_ack_out"}, ack_out, 1);
    chk({name, "_dout"},    dout,    8'h00);
    chk({name, "_busy"},    busy,    0);
    chk({name, "_arblost"}, arblost, 0);
  endtask

  // Behavioural bit controller: takes each new command, checks it, answers
  // bit_ack three cycles later with the next receive bit (and arblost if armed).
  initial begin : bitctl_model
    logic [2:0] c;
    logic       rxb;
    int         idx;
    forever begin
      @(negedge sysclk);
      if (bit_cmd != C_IDLE) begin
        c   = bit_cmd;
        idx = txn_idx;
        txn_idx++;
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cmd_unexpected: bit_cmd=%0d txd=%0b, required no command", bit_cmd, bit_txd);
        end else begin
          cmd_exp_t e;
          e = exp_cmd_q.pop_front();
          chk($sformatf("bit_cmd[%0d]", idx), bit_cmd, e.cmd);
          if (e.chk_txd) chk($sformatf("bit_txd[%0d]", idx), bit_txd, e.txd);
        end
        rxb = 1'b1;
        if ((c == C_READ || c == C_RDACK) && rx_q.size() != 0) rxb = rx_q.pop_front();
        repeat (2) @(negedge sysclk);
        bit_ack = 1'b1; bit_rxd = rxb; bit_arblost = (idx == arb_idx);
        @(negedge sysclk);
        bit_ack = 1'b0; bit_rxd = 1'b1; bit_arblost = 1'b0;
      end
    end
  end

  // Completion monitor: every cmd_ack pulse must match the next expected result.
  initial begin : done_mon
    forever begin
      @(negedge sysclk);
      if (cmd_ack === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_unexpected: cmd_ack=1, required 0");
        end else begin
          done_exp_t e;
          e = exp_done_q.pop_front();
          chk("done_bit_cmd", bit_cmd, C_IDLE);
          chk("done_arblost", arblost, e.arblost);
          if (e.chk_ack)  chk("done_ack_out", ack_out, e.ack_out);
          if (e.chk_dout) chk("done_dout", dout, e.dout);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge sysclk);
    chk_reset_vals("rst");
    nReset = 1'b1;
    repeat (2) @(negedge sysclk);

    // go with no flags: nothing happens, din is not loaded
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
    #1;
    chk("nogo_busy", busy, 0);
    chk("nogo_bit_cmd", bit_cmd, C_IDLE);
    chk("nogo_dout", dout, 8'h00);
    repeat (4) @(negedge sysclk);

    // START + WRITE 0xA5 + STOP, slave ACKs
    push_cmd(C_START, 1'b1, 1'b0);
    push_writes(8'hA5, 8);
    push_cmd(C_RDACK, 1'b1, 1'b0);
    push_cmd(C_STOP, 1'b1, 1'b0);
    rx_q.push_back(1'b0);
    push_done(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
    wait_done("wr");

    // enable low in the middle of a read clears everything, no completion
    push_reads(5);
    push_rx(8'hFF, 5);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    wait_idx("en_abort", 5);
    enable = 1'b0;
    @(negedge sysclk); #1;
    chk_reset_vals("en_abort");
    repeat (4) @(negedge sysclk);
    enable = 1'b1;
    repeat (2) @(negedge sysclk);

    // READ 0x3C with NACK; a go during the transfer is ignored
    push_reads(8);
    push_cmd(C_WRACK, 1'b1, 1'b1);
    push_rx(8'h3C, 8);
    push_done(1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    wait_idx("busy_go", 3);
    @(negedge sysclk);
    start = 1'b1; stop = 1'b1; write = 1'b1; din = 8'hFF; go = 1'b1;
    @(negedge sysclk);
    go = 1'b0; start = 1'b0; stop = 1'b0; write = 1'b0; din = 8'h00;
    wait_done("rd_nack");

    // START + READ 0x81 with ACK + STOP
    push_cmd(C_START, 1'b1, 1'b0);
    push_reads(8);
    push_cmd(C_WRACK, 1'b0, 1'b1);
    push_cmd(C_STOP, 1'b1, 1'b0);
    push_rx(8'h81, 8);
    push_done(1'b0, 1'b0, 8'h81, 1'b1, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    wait_done("rd_ack");

    // arbitration lost on the 4th WRITE bit: no STOP, arblost sticky
    arb_idx = 4;
    push_cmd(C_START, 1'b1, 1'b0);
    push_writes(8'hC3, 4);
    push_done(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    wait_done("arb");
    arb_idx = -1;
    repeat (3) @(negedge sysclk);
    chk("arb_sticky", arblost, 1);

    // stop-only, then a write issued in the cmd_ack cycle
    push_cmd(C_STOP, 1'b1, 1'b0);
    push_done(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    push_writes(8'h5A, 8);
    push_cmd(C_RDACK, 1'b1, 1'b0);
    rx_q.push_back(1'b0);
    push_done(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("stop_arblost_cleared", arblost, 0);
    chk("stop_busy", busy, 1);
    k = 0;
    while (cmd_ack !== 1'b1 && k < 100) begin
      @(negedge sysclk);
      k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL b2b_wait: cmd_ack=%0b, required 1", cmd_ack);
    end else begin
      chk("b2b_busy_ack_cycle", busy, 1);
      drive_go(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
      #1;
      chk("b2b_busy_held", busy, 1);
      chk("b2b_bit_cmd", bit_cmd, C_WRITE);
    end
    wait_done("b2b");

    // nReset low during READ bit 5: immediate abort, no completion
    push_reads(5);
    push_rx(8'hFF, 5);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF);
    wait_idx("rst_abort", 5);
    nReset = 1'b0;
    #1;
    chk_reset_vals("rst_abort");
    repeat (4) @(negedge sysclk);
    nReset = 1'b1;
    repeat (6) @(negedge sysclk);

    chk("cmd_queue_drained", exp_cmd_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
